// File: rtl/semi_graphics_gen.sv
// Semigraphics character-cell pixel generator (SG4, optional SG6).
// Optional SG6 mode (Mode/Css honoured) is built only when SEMI_SG6_EN is defined.
module semi_graphics_gen #(
    parameter int unsigned ROWS_PER_CHAR = 12,
    parameter int unsigned PIX_PER_CHAR  = 8
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       PixEn,
    input  logic       Load,
    input  logic [7:0] Data,
    input  logic       Mode,
    input  logic       Css,
    input  logic       RowAdv,
    input  logic       FieldStart,
    output logic       Pixel,
    output logic [3:0] Colour,
    output logic       Valid,
    output logic [4:0] RowCnt
);

    localparam int unsigned HALF  = PIX_PER_CHAR / 2;
    localparam int unsigned CNT_W = $clog2(PIX_PER_CHAR + 1);
    localparam int unsigned ROW_W = 5;
    localparam int unsigned COL_W = 4;

    logic [ROW_W-1:0]        row_cnt_q, row_cnt_d;
    logic [PIX_PER_CHAR-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [COL_W-1:0]        fg_q,      fg_d;
    logic                    pixel_q,   pixel_d;
    logic [COL_W-1:0]        colour_q,  colour_d;
    logic                    valid_q,   valid_d;

    logic                    elem_hi_c;
    logic                    elem_lo_c;
    logic [COL_W-1:0]        fg_load_c;
    logic [PIX_PER_CHAR-1:0] pattern_c;

    // Element pair and foreground for the byte on Data at the current scanline
    always_comb begin
        elem_hi_c = 1'b0;
        elem_lo_c = 1'b0;
        fg_load_c = '0;
`ifdef SEMI_SG6_EN
        if (Mode) begin
            if (row_cnt_q < ROW_W'(ROWS_PER_CHAR / 3)) begin
                elem_hi_c = Data[5];
                elem_lo_c = Data[4];
            end else if (row_cnt_q < ROW_W'((2 * ROWS_PER_CHAR) / 3)) begin
                elem_hi_c = Data[3];
                elem_lo_c = Data[2];
            end else begin
                elem_hi_c = Data[1];
                elem_lo_c = Data[0];
            end
            fg_load_c = {1'b0, Css, Data[7:6]} + COL_W'(1);
        end else begin
            if (row_cnt_q < ROW_W'(ROWS_PER_CHAR / 2)) begin
                elem_hi_c = Data[3];
                elem_lo_c = Data[2];
            end else begin
                elem_hi_c = Data[1];
                elem_lo_c = Data[0];
            end
            fg_load_c = {1'b0, Data[6:4]} + COL_W'(1);
        end
`else
        if (row_cnt_q < ROW_W'(ROWS_PER_CHAR / 2)) begin
            elem_hi_c = Data[3];
            elem_lo_c = Data[2];
        end else begin
            elem_hi_c = Data[1];
            elem_lo_c = Data[0];
        end
        fg_load_c = {1'b0, Data[6:4]} + COL_W'(1);
`endif
    end

`ifndef SEMI_SG6_EN
    logic unused_sg6_inputs;
    assign unused_sg6_inputs = &{1'b0, Mode, Css, Data[7]};
`endif

    // Left half (MSB side) takes the higher element bit
    always_comb begin
        pattern_c = '0;
        for (int unsigned i = 0; i < PIX_PER_CHAR; i++) begin
            pattern_c[i] = (i >= HALF) ? elem_hi_c : elem_lo_c;
        end
    end

    always_comb begin
        row_cnt_d = row_cnt_q;
        if (FieldStart) begin
            row_cnt_d = '0;
        end else if (RowAdv) begin
            if (row_cnt_q == ROW_W'(ROWS_PER_CHAR - 1)) begin
                row_cnt_d = '0;
            end else begin
                row_cnt_d = row_cnt_q + ROW_W'(1);
            end
        end
    end

    // A new Load abandons whatever is left of the previous cell
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        fg_d    = fg_q;
        if (PixEn) begin
            if (Load) begin
                shift_d = pattern_c;
                cnt_d   = CNT_W'(PIX_PER_CHAR);
                fg_d    = fg_load_c;
            end else if (cnt_q != '0) begin
                shift_d = {shift_q[PIX_PER_CHAR-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        valid_d  = (cnt_d != '0);
        pixel_d  = valid_d & shift_d[PIX_PER_CHAR-1];
        colour_d = pixel_d ? fg_d : '0;
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            row_cnt_q <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            fg_q      <= '0;
            pixel_q   <= 1'b0;
            colour_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            row_cnt_q <= row_cnt_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            fg_q      <= fg_d;
            pixel_q   <= pixel_d;
            colour_q  <= colour_d;
            valid_q   <= valid_d;
        end
    end

    assign Pixel  = pixel_q;
    assign Colour = colour_q;
    assign Valid  = valid_q;
    assign RowCnt = row_cnt_q;

endmodule

// File: tb/tb_semi_graphics_gen.sv
// Directed self-checking bench for semi_graphics_gen (default 12 rows x 8 pixels).
module tb_semi_graphics_gen;

    logic       Clk;
    logic       nReset;
    logic       PixEn;
    logic       Load;
    logic [7:0] Data;
    logic       Mode;
    logic       Css;
    logic       RowAdv;
    logic       FieldStart;
    logic       Pixel;
    logic [3:0] Colour;
    logic       Valid;
    logic [4:0] RowCnt;

    int total = 0;
    int bad   = 0;

    logic [7:0]  cap_pix;
    logic [7:0]  cap_val;
    logic [31:0] cap_col;
    logic        end_pix;
    logic        end_val;
    logic [3:0]  end_col;

    semi_graphics_gen dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .PixEn      (PixEn),
        .Load       (Load),
        .Data       (Data),
        .Mode       (Mode),
        .Css        (Css),
        .RowAdv     (RowAdv),
        .FieldStart (FieldStart),
        .Pixel      (Pixel),
        .Colour     (Colour),
        .Valid      (Valid),
        .RowCnt     (RowCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_row(input int n);
        FieldStart = 1'b1;
        tick();
        FieldStart = 1'b0;
        for (int i = 0; i < n; i++) begin
            RowAdv = 1'b1;
            tick();
            RowAdv = 1'b0;
        end
    endtask

    // Expected per-pixel colour nibbles: foreground where lit, black elsewhere
    function automatic logic [31:0] col_vec(input logic [7:0] pix, input logic [3:0] fg);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*4 +: 4] = pix[i] ? fg : 4'd0;
        return v;
    endfunction

    // Load one cell with PixEn every clock and record all 8 pixels plus the idle edge
    task automatic capture(input logic [7:0] d);
        Data  = d;
        Load  = 1'b1;
        PixEn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            Load = 1'b0;
            cap_pix[7-k]         = Pixel;
            cap_val[7-k]         = Valid;
            cap_col[(7-k)*4 +: 4] = Colour;
        end
        tick();
        end_pix = Pixel;
        end_val = Valid;
        end_col = Colour;
        PixEn   = 1'b0;
    endtask

    task automatic test_reset();
        nReset = 1'b0; Load = 1'b1; PixEn = 1'b1; RowAdv = 1'b1; FieldStart = 1'b0; Data = 8'hFF;
        tick();
        total++; if (Pixel !== 1'b0) begin bad++; $display("FAIL reset_pixel got=%b exp=0", Pixel); end
        total++; if (Colour !== 4'd0) begin bad++; $display("FAIL reset_colour got=%0d exp=0", Colour); end
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", Valid); end
        total++; if (RowCnt !== 5'd0) begin bad++; $display("FAIL reset_rowcnt got=%0d exp=0", RowCnt); end
        nReset = 1'b1; Load = 1'b0; PixEn = 1'b0; RowAdv = 1'b0; Data = 8'h00;
        tick();
    endtask

    task automatic test_rowcnt();
        set_row(0);
        for (int i = 0; i < 11; i++) begin
            RowAdv = 1'b1; tick(); RowAdv = 1'b0;
        end
        total++; if (RowCnt !== 5'd11) begin bad++; $display("FAIL rowcnt_11 got=%0d exp=11", RowCnt); end
        RowAdv = 1'b1; tick(); RowAdv = 1'b0;
        total++; if (RowCnt !== 5'd0) begin bad++; $display("FAIL rowcnt_wrap got=%0d exp=0", RowCnt); end
        set_row(5);
        total++; if (RowCnt !== 5'd5) begin bad++; $display("FAIL rowcnt_5 got=%0d exp=5", RowCnt); end
        FieldStart = 1'b1; RowAdv = 1'b1; tick(); FieldStart = 1'b0; RowAdv = 1'b0;
        total++; if (RowCnt !== 5'd0) begin bad++; $display("FAIL rowcnt_field_prio got=%0d exp=0", RowCnt); end
    endtask

    task automatic test_sg4_upper();
        set_row(0);
        // 0x9C: both upper elements set, so the whole scanline is lit in colour 2
        capture(8'h9C);
        total++; if (cap_pix !== 8'hFF) begin bad++; $display("FAIL sg4_9c_pix got=%h exp=ff", cap_pix); end
        total++; if (cap_val !== 8'hFF) begin bad++; $display("FAIL sg4_9c_valid got=%h exp=ff", cap_val); end
        total++; if (cap_col !== col_vec(8'hFF, 4'd2)) begin bad++; $display("FAIL sg4_9c_col got=%h exp=%h", cap_col, col_vec(8'hFF, 4'd2)); end
        total++; if ({end_val, end_pix, end_col} !== 6'd0) begin bad++; $display("FAIL sg4_9c_end got=%b%b%h exp=000", end_val, end_pix, end_col); end
        // 0x98: left element only -> left half lit
        capture(8'h98);
        total++; if (cap_pix !== 8'hF0) begin bad++; $display("FAIL sg4_98_pix got=%h exp=f0", cap_pix); end
        total++; if (cap_col !== col_vec(8'hF0, 4'd2)) begin bad++; $display("FAIL sg4_98_col got=%h exp=%h", cap_col, col_vec(8'hF0, 4'd2)); end
    endtask

    task automatic test_sg4_lower();
        set_row(6);
        capture(8'h9C);
        total++; if (cap_pix !== 8'h00) begin bad++; $display("FAIL sg4_row6_pix got=%h exp=00", cap_pix); end
        total++; if (cap_val !== 8'hFF) begin bad++; $display("FAIL sg4_row6_valid got=%h exp=ff", cap_val); end
        total++; if (cap_col !== 32'h0) begin bad++; $display("FAIL sg4_row6_col got=%h exp=0", cap_col); end
        total++; if (end_val !== 1'b0) begin bad++; $display("FAIL sg4_row6_end_valid got=%b exp=0", end_val); end
    endtask

    task automatic test_mode();
        Mode = 1'b1; Css = 1'b1;
`ifdef SEMI_SG6_EN
        set_row(0);
        capture(8'hD8);
        total++; if (cap_pix !== 8'h0F) begin bad++; $display("FAIL sg6_row0_pix got=%h exp=0f", cap_pix); end
        total++; if (cap_col !== col_vec(8'h0F, 4'd8)) begin bad++; $display("FAIL sg6_row0_col got=%h exp=%h", cap_col, col_vec(8'h0F, 4'd8)); end
        set_row(4);
        capture(8'hD8);
        total++; if (cap_pix !== 8'hF0) begin bad++; $display("FAIL sg6_row4_pix got=%h exp=f0", cap_pix); end
        total++; if (cap_col !== col_vec(8'hF0, 4'd8)) begin bad++; $display("FAIL sg6_row4_col got=%h exp=%h", cap_col, col_vec(8'hF0, 4'd8)); end
        set_row(8);
        capture(8'hD8);
        total++; if (cap_pix !== 8'h00) begin bad++; $display("FAIL sg6_row8_pix got=%h exp=00", cap_pix); end
        total++; if (cap_val !== 8'hFF) begin bad++; $display("FAIL sg6_row8_valid got=%h exp=ff", cap_val); end
`else
        // Mode/Css ignored: 0xD8 decodes as SG4, Data[3:2]=10, colour 5+1
        set_row(0);
        capture(8'hD8);
        total++; if (cap_pix !== 8'hF0) begin bad++; $display("FAIL sg4only_pix got=%h exp=f0", cap_pix); end
        total++; if (cap_col !== col_vec(8'hF0, 4'd6)) begin bad++; $display("FAIL sg4only_col got=%h exp=%h", cap_col, col_vec(8'hF0, 4'd6)); end
`endif
        Mode = 1'b0; Css = 1'b0;
    endtask

    task automatic test_hold_and_sample();
        logic [7:0] seen;
        set_row(0);
        Data = 8'h98; Load = 1'b1; PixEn = 1'b1;
        tick();
        Load = 1'b0; PixEn = 1'b0;
        seen[7] = Pixel;
        // Load without PixEn is ignored; Data and row changes must not touch the cell
        Load = 1'b1; Data = 8'hFF; tick(); Load = 1'b0; Data = 8'h00;
        for (int i = 0; i < 6; i++) begin
            RowAdv = 1'b1; tick(); RowAdv = 1'b0;
        end
        total++; if ({Valid, Pixel, Colour} !== {1'b1, 1'b1, 4'd2}) begin bad++; $display("FAIL hold_outputs got=%b%b%0d exp=1,1,2", Valid, Pixel, Colour); end
        total++; if (RowCnt !== 5'd6) begin bad++; $display("FAIL hold_rowcnt got=%0d exp=6", RowCnt); end
        PixEn = 1'b1;
        for (int k = 1; k < 8; k++) begin
            tick();
            seen[7-k] = Pixel;
        end
        tick();
        PixEn = 1'b0;
        total++; if (seen !== 8'hF0) begin bad++; $display("FAIL hold_pattern got=%h exp=f0", seen); end
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL hold_end_valid got=%b exp=0", Valid); end
        Load = 1'b1; Data = 8'hFF; tick(); Load = 1'b0;
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL load_no_pixen got=%b exp=0", Valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] first3;
        int         vcount;
        set_row(0);
        Data = 8'h8C; Load = 1'b1; PixEn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            Load = 1'b0;
            first3[2-k] = Pixel;
        end
        total++; if (first3 !== 3'b111) begin bad++; $display("FAIL b2b_first3 got=%b exp=111", first3); end
        Data = 8'h83; Load = 1'b1;
        tick();
        Load = 1'b0;
        total++; if ({Valid, Pixel, Colour} !== {1'b1, 1'b0, 4'd0}) begin bad++; $display("FAIL b2b_restart got=%b%b%0d exp=1,0,0", Valid, Pixel, Colour); end
        vcount = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (Valid === 1'b1) vcount++;
        end
        PixEn = 1'b0;
        total++; if (vcount !== 8) begin bad++; $display("FAIL b2b_valid_len got=%0d exp=8", vcount); end
    endtask

    task automatic test_reset_mid();
        set_row(3);
        Data = 8'h9C; Load = 1'b1; PixEn = 1'b1;
        tick(); Load = 1'b0; tick();
        nReset = 1'b0; Load = 1'b1; RowAdv = 1'b1;
        tick();
        total++; if ({Valid, Pixel, Colour, RowCnt} !== 11'd0) begin bad++; $display("FAIL reset_mid got=%b%b%0d,%0d exp=0", Valid, Pixel, Colour, RowCnt); end
        nReset = 1'b1; Load = 1'b0; RowAdv = 1'b0;
        tick();
        total++; if ({Valid, Pixel, Colour} !== 6'd0) begin bad++; $display("FAIL reset_release_idle got=%b%b%0d exp=0", Valid, Pixel, Colour); end
        PixEn = 1'b0;
    endtask

    initial begin
        nReset = 1'b0; PixEn = 1'b0; Load = 1'b0; Data = 8'h00; Mode = 1'b0;
        Css = 1'b0; RowAdv = 1'b0; FieldStart = 1'b0;
        test_reset();
        test_rowcnt();
        test_sg4_upper();
        test_sg4_lower();
        test_mode();
        test_hold_and_sample();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
